cdr_lock_ctrl: RTL and testbench
================================

Name: cdr_lock_ctrl

Overview:
Acquisition/lock sequencer for the CDR loop (VCO, sampler, MMPD, loop filter). It monitors the MMPD output f_n over fixed sample windows and selects loop-filter gain (coarse, fine, tracking). It also clears or holds the loop filter and reports lock and loss-of-lock. It runs on the system clock and receives a one-cycle strobe per recovered sample.

Parameters:
WIN_LOG2, 6, log2 of samples per measurement window (window N = 64)
ACQ_THR, 2048, window sum of |f_n| below which COARSE may hand over to FINE
LOCK_THR, 512, window sum of |f_n| below which a window counts as good
UNLOCK_THR, 4096, window sum of |f_n| at or above which a window counts as bad
COARSE_WINS, 8, minimum windows spent in COARSE
LOCK_WINS, 4, consecutive good windows required to declare lock
UNLOCK_WINS, 2, consecutive bad windows that drop lock
FINE_TMO, 32, windows allowed in FINE before restarting acquisition
CLEAR_CYC, 4, clk cycles filt_clear is asserted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  controller enable; low forces IDLE
f_valid  in  1  one-cycle strobe, f_n valid (already synchronised to clk)
f_n  in  16 signed  MMPD output
force_relock  in  1  one-cycle request to restart acquisition
gain_sel  out  2  loop-filter gain: 2=coarse, 1=fine, 0=track, 3=unused
filt_clear  out  1  clear loop-filter integrator
filt_hold  out  1  freeze loop-filter integrator
locked  out  1  lock indicator
lock_lost  out  1  one-cycle pulse on LOCKED exit caused by bad windows
state  out  3  current state encoding (debug)

Behaviour:
- Reset (rst=0, async): state=IDLE; gain_sel=2, filt_clear=0, filt_hold=1, locked=0, lock_lost=0; all counters and accumulator cleared.
- State encodings: IDLE=0, CLEAR=1, COARSE=2, FINE=3, LOCKED=4. All outputs are registered and reflect the current state (Moore), except lock_lost, which is registered on the transition.
- IDLE: filt_hold=1, gain_sel=2. When en=1, go to CLEAR on the next cycle.
- CLEAR: filt_clear=1 and filt_hold=0 for exactly CLEAR_CYC cycles, then go to COARSE.
- COARSE: gain_sel=2. A window ends on the 2^WIN_LOG2-th f_valid strobe. Go to FINE at the end of a window when both hold:
  - windows completed in COARSE >= COARSE_WINS, including the current one;
  - window sum < ACQ_THR.
- FINE: gain_sel=1.
  - Good window: count it. When good-run reaches LOCK_WINS, go to LOCKED.
  - Non-good window: reset the good-run counter to 0.
  - At FINE_TMO windows completed in FINE without reaching lock, go to CLEAR.
- LOCKED: gain_sel=0, locked=1.
  - Bad window: increment the bad-run counter. Any window that is not bad resets it to 0.
  - When bad-run reaches UNLOCK_WINS: pulse lock_lost for one cycle, set locked=0, and go to COARSE. CLEAR is skipped, so the integrator is kept.
- Window measurement:
  - abs(f_n) saturates -32768 to 32767.
  - Accumulator is unsigned, 15+WIN_LOG2 bits, so it cannot overflow.
  - The sum used for the decision includes the closing sample. On the cycle after the strobe, the accumulator restarts from 0 and the next strobe's sample is added.
  - Threshold compares are unsigned.
- State entry: on every state entry, the window sample count, accumulator, and all window/run counters reset to 0. Any partial window is discarded.
- Priority, highest first: en=0 (go to IDLE next cycle from any state), then force_relock (go to CLEAR from COARSE, FINE or LOCKED; ignored in IDLE and CLEAR), then the window decision.
  - force_relock in LOCKED does not pulse lock_lost.
  - If f_valid and force_relock coincide, the sample is discarded.
- f_valid outside COARSE, FINE and LOCKED is ignored.
- Back-to-back f_valid on consecutive cycles must be handled without losing samples.
- Async reset mid-window: everything returns to reset values immediately. After rst is released, the block resumes from IDLE.

Test Plan:
- Reset then en=1, f_valid every 4 clk with f_n=0: state goes IDLE→CLEAR; filt_clear is high for exactly 4 cycles; COARSE for exactly 8 windows (512 strobes); FINE for 4 windows; then LOCKED with locked=1 and gain_sel=0.
- In COARSE, feed f_n=+40 (window sum 2560 ≥ ACQ_THR) for 12 windows, then f_n=-20 (sum 1280): state stays in COARSE until the first window with sum 1280 closes, then goes to FINE.
- In LOCKED, feed f_n=-32768 for 2 windows: sum saturates at 64×32767; lock_lost pulses exactly once; locked falls; state=COARSE; filt_clear stays 0.
- In LOCKED, feed alternating bad/good windows (f_n=100, then 0): bad-run never reaches 2, and state stays LOCKED.
- In FINE, feed f_n=10 (sum 640, not good) for 32 windows: at the 32nd window close, state goes to CLEAR.
- force_relock in FINE mid-window: go to CLEAR next cycle and discard the partial sum. en=0 in LOCKED: IDLE next cycle with filt_hold=1. rst pulse mid-window: all outputs return to reset values immediately.

Source files
------------

// File: rtl/cdr_lock_ctrl.sv
// CDR acquisition/lock sequencer: measures MMPD activity over fixed sample windows,
// steps the loop-filter gain coarse -> fine -> track and reports lock / loss-of-lock.
module cdr_lock_ctrl #(
   parameter int WIN_LOG2    = 6,
   parameter int ACQ_THR     = 2048,
   parameter int LOCK_THR    = 512,
   parameter int UNLOCK_THR  = 4096,
   parameter int COARSE_WINS = 8,
   parameter int LOCK_WINS   = 4,
   parameter int UNLOCK_WINS = 2,
   parameter int FINE_TMO    = 32,
   parameter int CLEAR_CYC   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        f_valid,
   input  logic [15:0] f_n,
   input  logic        force_relock,
   output logic [1:0]  gain_sel,
   output logic        filt_clear,
   output logic        filt_hold,
   output logic        locked,
   output logic        lock_lost,
   output logic [2:0]  state
);

   // Handshake: f_valid is a single-cycle qualifier for f_n with no back-pressure;
   // a sample is consumed on every clk edge where f_valid is high in an active state.

   localparam int AW = 15 + WIN_LOG2;

   localparam logic [AW-1:0]       ACQ_THR_C     = AW'(ACQ_THR);
   localparam logic [AW-1:0]       LOCK_THR_C    = AW'(LOCK_THR);
   localparam logic [AW-1:0]       UNLOCK_THR_C  = AW'(UNLOCK_THR);
   localparam logic [7:0]          COARSE_WINS_C = 8'(COARSE_WINS);
   localparam logic [7:0]          LOCK_WINS_C   = 8'(LOCK_WINS);
   localparam logic [7:0]          UNLOCK_WINS_C = 8'(UNLOCK_WINS);
   localparam logic [7:0]          FINE_TMO_C    = 8'(FINE_TMO);
   localparam logic [7:0]          CLEAR_LAST_C  = 8'(CLEAR_CYC - 1);
   localparam logic [WIN_LOG2-1:0] SMP_LAST_C    = {WIN_LOG2{1'b1}};
   localparam logic [WIN_LOG2-1:0] SMP_ONE_C     = WIN_LOG2'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_COARSE = 3'd2,
      S_FINE   = 3'd3,
      S_LOCKED = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [WIN_LOG2-1:0] smp_cnt_q, smp_cnt_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [7:0]          win_cnt_q, win_cnt_d;
   logic [7:0]          run_cnt_q, run_cnt_d;
   logic [7:0]          clr_cnt_q, clr_cnt_d;
   logic                lock_lost_q, lock_lost_d;
   logic [1:0]          gain_q, gain_d;
   logic                clear_q, clear_d;
   logic                hold_q, hold_d;
   logic                locked_q, locked_d;

   logic [15:0]   mag_full_v;
   logic [14:0]   mag_v;
   logic [AW-1:0] sum_v;
   logic [7:0]    wins_v;
   logic [7:0]    run_inc_v;
   logic          active_v;

   // |f_n| with -32768 clipped to 32767 so it fits the 15-bit magnitude.
   always_comb begin
      mag_full_v = f_n[15] ? (16'd0 - f_n) : f_n;
      mag_v      = mag_full_v[15] ? 15'h7fff : mag_full_v[14:0];
      sum_v      = acc_q + {{WIN_LOG2{1'b0}}, mag_v};
      wins_v     = (win_cnt_q == 8'hff) ? win_cnt_q : win_cnt_q + 8'd1;
      run_inc_v  = (run_cnt_q == 8'hff) ? run_cnt_q : run_cnt_q + 8'd1;
      active_v   = (state_q == S_COARSE) || (state_q == S_FINE) || (state_q == S_LOCKED);
   end

   always_comb begin
      state_d     = state_q;
      smp_cnt_d   = smp_cnt_q;
      acc_d       = acc_q;
      win_cnt_d   = win_cnt_q;
      run_cnt_d   = run_cnt_q;
      clr_cnt_d   = clr_cnt_q;
      lock_lost_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            if (clr_cnt_q == CLEAR_LAST_C) state_d = S_COARSE;
            else clr_cnt_d = clr_cnt_q + 8'd1;
         end
         S_COARSE, S_FINE, S_LOCKED: begin
            if (f_valid) begin
               if (smp_cnt_q == SMP_LAST_C) begin
                  smp_cnt_d = '0;
                  acc_d     = '0;
                  win_cnt_d = wins_v;
                  if (state_q == S_COARSE) begin
                     if ((wins_v >= COARSE_WINS_C) && (sum_v < ACQ_THR_C)) state_d = S_FINE;
                  end else if (state_q == S_FINE) begin
                     if (sum_v < LOCK_THR_C) begin
                        run_cnt_d = run_inc_v;
                        if (run_inc_v >= LOCK_WINS_C) state_d = S_LOCKED;
                     end else begin
                        run_cnt_d = '0;
                     end
                     if ((state_d != S_LOCKED) && (wins_v >= FINE_TMO_C)) state_d = S_CLEAR;
                  end else begin
                     if (sum_v >= UNLOCK_THR_C) begin
                        run_cnt_d = run_inc_v;
                        if (run_inc_v >= UNLOCK_WINS_C) begin
                           state_d     = S_COARSE;
                           lock_lost_d = 1'b1;
                        end
                     end else begin
                        run_cnt_d = '0;
                     end
                  end
               end else begin
                  smp_cnt_d = smp_cnt_q + SMP_ONE_C;
                  acc_d     = sum_v;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!en) begin
         state_d     = S_IDLE;
         lock_lost_d = 1'b0;
      end else if (force_relock && active_v) begin
         state_d     = S_CLEAR;
         lock_lost_d = 1'b0;
      end

      // Every state entry starts from a clean measurement; partial windows are dropped.
      if (state_d != state_q) begin
         smp_cnt_d = '0;
         acc_d     = '0;
         win_cnt_d = '0;
         run_cnt_d = '0;
         clr_cnt_d = '0;
      end
   end

   always_comb begin
      gain_d   = 2'd2;
      clear_d  = 1'b0;
      hold_d   = 1'b0;
      locked_d = 1'b0;
      case (state_d)
         S_IDLE:   hold_d   = 1'b1;
         S_CLEAR:  clear_d  = 1'b1;
         S_FINE:   gain_d   = 2'd1;
         S_LOCKED: begin
            gain_d   = 2'd0;
            locked_d = 1'b1;
         end
         default:  gain_d   = 2'd2;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         smp_cnt_q   <= '0;
         acc_q       <= '0;
         win_cnt_q   <= '0;
         run_cnt_q   <= '0;
         clr_cnt_q   <= '0;
         lock_lost_q <= 1'b0;
         gain_q      <= 2'd2;
         clear_q     <= 1'b0;
         hold_q      <= 1'b1;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         smp_cnt_q   <= smp_cnt_d;
         acc_q       <= acc_d;
         win_cnt_q   <= win_cnt_d;
         run_cnt_q   <= run_cnt_d;
         clr_cnt_q   <= clr_cnt_d;
         lock_lost_q <= lock_lost_d;
         gain_q      <= gain_d;
         clear_q     <= clear_d;
         hold_q      <= hold_d;
         locked_q    <= locked_d;
      end
   end

   assign gain_sel   = gain_q;
   assign filt_clear = clear_q;
   assign filt_hold  = hold_q;
   assign locked     = locked_q;
   assign lock_lost  = lock_lost_q;
   assign state      = state_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Bench for cdr_lock_ctrl: window-queue reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_cdr_lock_ctrl;

   localparam int WIN_N = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        f_valid;
   logic [15:0] f_n;
   logic        force_relock;
   logic [1:0]  gain_sel;
   logic        filt_clear;
   logic        filt_hold;
   logic        locked;
   logic        lock_lost;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;
   int clr_seen = 0;
   int lost_seen = 0;

   cdr_lock_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .f_valid      (f_valid),
      .f_n          (f_n),
      .force_relock (force_relock),
      .gain_sel     (gain_sel),
      .filt_clear   (filt_clear),
      .filt_hold    (filt_hold),
      .locked       (locked),
      .lock_lost    (lock_lost),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: state number plus a queue of the current window's magnitudes.
   int          m_state = 0;
   int unsigned m_q[$];
   int          m_nwin = 0;
   int          m_run = 0;
   int          m_clr = 0;
   int          m_lost = 0;

   function automatic int exp_gain(input int st);
      if (st == 3) return 1;
      if (st == 4) return 0;
      return 2;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_state = 0; m_q.delete(); m_nwin = 0; m_run = 0; m_clr = 0; m_lost = 0;
      end else begin
         int nxt;
         int lost;
         int sv;
         int unsigned mag;
         int unsigned sum;
         nxt = m_state;
         lost = 0;
         if (!en) nxt = 0;
         else if (force_relock && m_state >= 2) nxt = 1;
         else if (m_state == 0) nxt = 1;
         else if (m_state == 1) begin
            m_clr++;
            if (m_clr == 4) nxt = 2;
         end else if (f_valid) begin
            sv = int'($signed(f_n));
            mag = (sv < 0) ? -sv : sv;
            if (mag > 32767) mag = 32767;
            m_q.push_back(mag);
            if (m_q.size() == WIN_N) begin
               sum = 0;
               foreach (m_q[k]) sum += m_q[k];
               m_q.delete();
               m_nwin++;
               if (m_state == 2) begin
                  if (m_nwin >= 8 && sum < 2048) nxt = 3;
               end else if (m_state == 3) begin
                  if (sum < 512) m_run++; else m_run = 0;
                  if (m_run >= 4) nxt = 4;
                  else if (m_nwin >= 32) nxt = 1;
               end else begin
                  if (sum >= 4096) m_run++; else m_run = 0;
                  if (m_run >= 2) begin nxt = 2; lost = 1; end
               end
            end
         end
         if (nxt != m_state) begin
            m_q.delete(); m_nwin = 0; m_run = 0; m_clr = 0;
         end
         m_state = nxt;
         m_lost = lost;
      end
   end

   // Compare process: every output against the model on each falling edge.
   initial forever begin
      @(negedge clk);
      chk("state", int'(state), m_state);
      chk("gain_sel", int'(gain_sel), exp_gain(m_state));
      chk("filt_clear", int'(filt_clear), int'(m_state == 1));
      chk("filt_hold", int'(filt_hold), int'(m_state == 0));
      chk("locked", int'(locked), int'(m_state == 4));
      chk("lock_lost", int'(lock_lost), m_lost);
      if (filt_clear) clr_seen++;
      if (lock_lost) lost_seen++;
   end

   task automatic send(input int v, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         f_valid = 1'b1;
         f_n = 16'(v);
         @(negedge clk);
         f_valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_state"}, int'(state), 0);
      chk({tag, "_gain"}, int'(gain_sel), 2);
      chk({tag, "_hold"}, int'(filt_hold), 1);
      chk({tag, "_clear"}, int'(filt_clear), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_lost"}, int'(lock_lost), 0);
   endtask

   initial begin
      int n_clr;
      int lost0;
      int clr0;
      rst = 1'b1; en = 1'b0; f_valid = 1'b0; f_n = 16'd0; force_relock = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("rst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_no_en", int'(state), 0);

      // Acquisition with f_n = 0, strobe every 4 clk.
      en = 1'b1;
      @(negedge clk);
      chk("enter_clear", int'(state), 1);
      n_clr = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (filt_clear) n_clr++;
         else break;
      end
      chk("clear_cycles", n_clr, 4);
      chk("after_clear", int'(state), 2);
      send(0, 511, 4);
      chk("coarse_511", int'(state), 2);
      send(0, 1, 4);
      chk("coarse_to_fine", int'(state), 3);
      chk("fine_gain", int'(gain_sel), 1);
      send(0, 255, 4);
      chk("fine_255", int'(state), 3);
      send(0, 1, 4);
      chk("fine_to_locked", int'(state), 4);
      chk("locked_flag", int'(locked), 1);
      chk("locked_gain", int'(gain_sel), 0);

      // Alternating bad/good windows, back-to-back strobes.
      for (int i = 0; i < 3; i++) begin
         send(100, WIN_N, 1);
         send(0, WIN_N, 1);
         chk("alt_stay_locked", int'(state), 4);
      end

      // Two saturating bad windows drop lock without clearing the filter.
      #1;
      lost0 = lost_seen;
      clr0 = clr_seen;
      send(-32768, 2 * WIN_N, 1);
      chk("unlock_state", int'(state), 2);
      chk("unlock_locked", int'(locked), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("lost_pulses", lost_seen - lost0, 1);
      chk("no_clear_on_unlock", clr_seen - clr0, 0);

      // COARSE hand-over waits for a quiet window.
      send(40, 12 * WIN_N, 1);
      chk("coarse_noisy", int'(state), 2);
      send(-20, WIN_N, 1);
      chk("coarse_quiet_to_fine", int'(state), 3);

      // FINE timeout.
      send(10, 31 * WIN_N, 1);
      chk("fine_31", int'(state), 3);
      send(10, WIN_N, 1);
      chk("fine_timeout", int'(state), 1);
      repeat (5) @(negedge clk);
      chk("timeout_to_coarse", int'(state), 2);

      // force_relock mid-window in FINE, coinciding with a strobe.
      send(0, 8 * WIN_N, 1);
      chk("reacq_fine", int'(state), 3);
      send(500, 10, 1);
      f_valid = 1'b1; f_n = 16'd500; force_relock = 1'b1;
      @(negedge clk);
      f_valid = 1'b0; force_relock = 1'b0;
      chk("relock_clear", int'(state), 1);
      repeat (5) @(negedge clk);
      chk("relock_coarse", int'(state), 2);
      send(0, 8 * WIN_N - 1, 1);
      chk("relock_511", int'(state), 2);
      send(0, 1, 1);
      chk("relock_fine", int'(state), 3);
      send(0, 4 * WIN_N, 1);
      chk("relock_locked", int'(state), 4);

      // en low from LOCKED.
      en = 1'b0;
      @(negedge clk);
      chk("dis_state", int'(state), 0);
      chk("dis_hold", int'(filt_hold), 1);
      chk("dis_locked", int'(locked), 0);
      force_relock = 1'b1;
      @(negedge clk);
      force_relock = 1'b0;
      chk("relock_ignored_idle", int'(state), 0);
      #1;
      chk("lost_total", lost_seen - lost0, 1);

      // Asynchronous reset mid-window.
      @(negedge clk);
      en = 1'b1;
      repeat (5) @(negedge clk);
      chk("pre_rst_coarse", int'(state), 2);
      send(300, 20, 1);
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_clear", int'(state), 1);
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
